// File: rtl/vga_bounce_box.sv
// Pixel stage after the 640x480 VGA timing generator: draws a bouncing box over a
// bordered background and re-times the syncs so they line up with the colour.

module vga_bounce_axis #(
    parameter int LIMIT = 608,
    parameter int STEP  = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       move,
    output logic [9:0] pos,
    output logic       dir,
    output logic       hit
);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] LIMIT11 = 11'(LIMIT);

    logic [10:0] fwd;
    logic [9:0]  pos_nxt;

    // 11-bit sums so pos + STEP can never wrap before the limit compare
    always_comb begin
        fwd     = {1'b0, pos} + STEP11;
        hit     = 1'b0;
        pos_nxt = pos;
        if (dir) begin
            hit     = (fwd >= LIMIT11);
            pos_nxt = hit ? 10'(LIMIT) : fwd[9:0];
        end else begin
            hit     = ({1'b0, pos} <= STEP11);
            pos_nxt = hit ? 10'd0 : pos - 10'(STEP);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pos <= 10'd0;
            dir <= 1'b1;
        end else if (move) begin
            pos <= pos_nxt;
            if (hit)
                dir <= ~dir;
        end
    end
endmodule

module vga_bounce_box #(
    parameter int         HBP       = 144,
    parameter int         VBP       = 31,
    parameter int         VFP       = 511,
    parameter int         SIZE      = 32,
    parameter int         STEP      = 2,
    parameter logic [7:0] BOX_COLOR = 8'hE0,
    parameter logic [7:0] BG_COLOR  = 8'h03
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       vidon,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pause,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] bounce_cnt
);
    localparam int NUM_AXES = 2;
    localparam int XMAX = 640 - SIZE;
    localparam int YMAX = 480 - SIZE;

    logic                     tick, move;
    logic [NUM_AXES-1:0][9:0] pos;
    logic [NUM_AXES-1:0]      dir, hit;
    logic [9:0]               x, y;
    logic                     dx, dy;

    // hc == 0 keeps the strobe to one clock while vc sits on VFP for a whole line
    assign tick = (hc == 10'd0) && (vc == 10'(VFP));
    assign move = tick & ~pause;

    generate
        for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
            vga_bounce_axis #(
                .LIMIT (a == 0 ? XMAX : YMAX),
                .STEP  (STEP)
            ) u_axis (
                .clk  (clk),
                .clr  (clr),
                .move (move),
                .pos  (pos[a]),
                .dir  (dir[a]),
                .hit  (hit[a])
            );
        end
    endgenerate

    assign x  = pos[0];
    assign y  = pos[1];
    assign dx = dir[0];
    assign dy = dir[1];

    // a corner hit is one bounce, not two
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            bounce_cnt <= 8'd0;
        else if (move && (|hit))
            bounce_cnt <= bounce_cnt + 8'd1;
    end

    logic [9:0] col, row;
    logic       in_box, border;
    logic [7:0] pix, rgb;

    assign col = hc - 10'(HBP);
    assign row = vc - 10'(VBP);

    always_comb begin
        in_box = (col >= x) && ({1'b0, col} < ({1'b0, x} + 11'(SIZE))) &&
                 (row >= y) && ({1'b0, row} < ({1'b0, y} + 11'(SIZE)));
        border = (col < 10'd4) || (col >= 10'd636) || (row < 10'd4) || (row >= 10'd476);
        pix    = 8'h00;
        if (vidon) begin
            if (in_box)
                pix = BOX_COLOR;
            else if (border)
                pix = 8'hFF;
            else
                pix = BG_COLOR;
        end
    end

    // syncs share the colour register stage so they stay aligned
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rgb   <= 8'h00;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= pix;
            hsync <= hsync_in;
            vsync <= vsync_in;
        end
    end

    assign {red, green, blue} = rgb;
endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: pixel map, bounces, pause, counter wrap,
// sync alignment and asynchronous reset, with hand-computed expectations.

module tb_vga_bounce_box;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [9:0] hc = 10'd0;
    logic [9:0] vc = 10'd0;
    logic       vidon = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       hsync, vsync;
    logic [7:0] bounce_cnt;
    logic [7:0] rgb;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    vga_bounce_box dut (
        .clk        (clk),
        .clr        (clr),
        .hc         (hc),
        .vc         (vc),
        .vidon      (vidon),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pause      (pause),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .bounce_cnt (bounce_cnt)
    );

    assign rgb = {red, green, blue};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n frame ticks back to back; the bench drives hc/vc directly
    task automatic ticks(input int n);
        hc = 10'd0; vc = 10'd511; vidon = 1'b0;
        repeat (n) @(posedge clk);
        #1 hc = 10'd1;
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic vid,
                       input logic [7:0] exp);
        hc = 10'(h); vc = 10'(v); vidon = vid;
        @(posedge clk); #1;
        chk(tag, {24'd0, rgb}, {24'd0, exp});
    endtask

    task automatic state(input string tag, input int ex, input int edx, input int ey,
                         input int edy, input int eb);
        chk({tag, "_x"},  {22'd0, dut.x},  ex);
        chk({tag, "_dx"}, {31'd0, dut.dx}, edx);
        chk({tag, "_y"},  {22'd0, dut.y},  ey);
        chk({tag, "_dy"}, {31'd0, dut.dy}, edy);
        chk({tag, "_bc"}, {24'd0, bounce_cnt}, eb);
    endtask

    initial begin
        int vl[8];
        logic [1:0] prev, cur;
        vl = '{0, 1, 2, 3, 509, 510, 511, 512};

        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rgb", {24'd0, rgb}, 32'h0);
        chk("rst_sync", {30'd0, hsync, vsync}, 32'h3);
        state("rst", 0, 1, 0, 1, 0);
        clr = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;

        // pixel map with the box at (0,0)
        pix("px_box",    154, 41,  1'b1, 8'hE0);
        hc = 10'd244; vc = 10'd131; vidon = 1'b1;
        #1 chk("lat_hold", {24'd0, rgb}, 32'hE0);
        @(posedge clk); #1 chk("px_bg", {24'd0, rgb}, 32'h03);
        pix("px_rborder", 781, 231, 1'b1, 8'hFF);
        pix("px_lborder", 146, 231, 1'b1, 8'hFF);
        pix("px_blank",   154, 41,  1'b0, 8'h00);
        pix("px_box_lr",  175, 62,  1'b1, 8'hE0);
        pix("px_box_out", 176, 41,  1'b1, 8'h03);
        pix("px_box_bot", 154, 63,  1'b1, 8'h03);

        // first tick: box moves to (2,2)
        ticks(1);
        state("t1", 2, 1, 2, 1, 0);
        pix("t1_border", 145, 41, 1'b1, 8'hFF);
        pix("t1_over",   146, 33, 1'b1, 8'hE0);
        pix("t1_far",    177, 41, 1'b1, 8'hE0);
        pix("t1_past",   178, 41, 1'b1, 8'h03);

        // run up to just before the right wall (y already bounced at tick 224)
        ticks(302);
        state("t303", 606, 1, 290, 0, 1);

        // pause across a tick that would otherwise hit
        pause = 1'b1;
        ticks(3);
        state("pause", 606, 1, 290, 0, 1);
        pause = 1'b0;

        ticks(1);
        state("t304", 608, 0, 288, 0, 2);
        pix("t304_edge", 783, 331, 1'b1, 8'hE0);
        pix("t304_left", 751, 331, 1'b1, 8'h03);
        ticks(1);
        state("t305", 606, 0, 286, 0, 2);

        // corner hit at tick 4256: left wall and bottom wall together
        ticks(3950);
        state("t4255", 2, 0, 446, 1, 31);
        ticks(1);
        state("t4256", 0, 1, 448, 0, 32);

        // counter wraps on the 256th bouncing frame (tick 34048)
        ticks(29791);
        state("t34047", 2, 0, 2, 0, 255);
        ticks(1);
        state("t34048", 0, 1, 0, 1, 0);

        // sync alignment across top and bottom lines of a frame
        hsync_in = 1'b1; vsync_in = 1'b1; vidon = 1'b0;
        @(posedge clk); #1;
        prev = 2'b11;
        foreach (vl[i]) begin
            for (int h = 0; h < 800; h++) begin
                cur = {(h >= 96), (vl[i] >= 2)};
                hc = 10'(h); vc = 10'(vl[i]);
                vidon = (h >= 144) && (h < 784) && (vl[i] >= 31) && (vl[i] < 511);
                {hsync_in, vsync_in} = cur;
                #1 chk("sync_hold", {30'd0, hsync, vsync}, {30'd0, prev});
                @(posedge clk); #1;
                chk("sync_new", {30'd0, hsync, vsync}, {30'd0, cur});
                prev = cur;
            end
        end

        // asynchronous reset mid-line
        hc = 10'd300; vc = 10'd200; vidon = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_sync", {30'd0, hsync, vsync}, 32'h0);
        #1 clr = 1'b1;
        #1;
        chk("arst_rgb", {24'd0, rgb}, 32'h0);
        chk("arst_sync", {30'd0, hsync, vsync}, 32'h3);
        state("arst", 0, 1, 0, 1, 0);
        @(posedge clk); #1 clr = 1'b0;
        ticks(1);
        state("post_rst", 2, 1, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
